// File: rtl/led_value_capture_if.sv
// Signal bundle between the NES debug sources, the two push-buttons and the
// seven-segment value capture stage.
interface led_value_capture_if;
   logic [127:0] src_data;
   logic         btn_page;
   logic         btn_freeze;
   logic [31:0]  value;
   logic [7:0]   enable;
   logic [1:0]   page;
   logic         frozen;

   modport master (
      output src_data, btn_page, btn_freeze,
      input  value, enable, page, frozen
   );

   modport slave (
      input  src_data, btn_page, btn_freeze,
      output value, enable, page, frozen
   );
endinterface

// File: rtl/led_value_capture.sv
// Picks one of four debug words for the 8-digit display, rate-limits reloads,
// blanks leading zeros and debounces the page / freeze buttons.
module led_value_capture #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int REFRESH_CYCLES  = 2000000
) (
   input logic              clk,
   input logic              reset_n,
   led_value_capture_if.slave bus
);
   localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RCW = $clog2(REFRESH_CYCLES + 1);
   localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCW-1:0] RF_LAST = RCW'(REFRESH_CYCLES - 1);

   logic [1:0] btn_raw;
   logic [1:0] btn_rise;

   assign btn_raw = {bus.btn_freeze, bus.btn_page};

   // Bit 0 is the page button, bit 1 the freeze button.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic           sync1_reg;
         logic           sync2_reg;
         logic           level_reg;
         logic [DCW-1:0] cnt_reg;
         logic           differ;
         logic           qualify;

         assign differ       = (sync2_reg != level_reg);
         assign qualify      = differ && (cnt_reg == DB_LAST);
         assign btn_rise[gi] = qualify && sync2_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               level_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               if (!differ) begin
                  cnt_reg <= '0;
               end else if (qualify) begin
                  level_reg <= sync2_reg;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end
      end
   endgenerate

   logic           page_pulse;
   logic           freeze_pulse;
   logic [31:0]    value_reg;
   logic [7:0]     enable_reg;
   logic [1:0]     page_reg;
   logic           frozen_reg;
   logic [RCW-1:0] timer_reg;
   logic           refresh_tick;
   logic [1:0]     sel_page;
   logic [31:0]    sel_word;
   logic [7:0]     sel_mask;

   assign page_pulse   = btn_rise[0];
   assign freeze_pulse = btn_rise[1];
   assign refresh_tick = (timer_reg == RF_LAST);

   // A page step loads from the page being entered, not the one being left.
   assign sel_page = page_pulse ? page_reg + 2'd1 : page_reg;
   assign sel_word = bus.src_data[{sel_page, 5'd0} +: 32];

   assign sel_mask[0] = 1'b1;
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_mask
         assign sel_mask[gi] = |sel_word[31:4*gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_reg  <= '0;
         enable_reg <= 8'h01;
         page_reg   <= '0;
         frozen_reg <= 1'b0;
         timer_reg  <= '0;
      end else if (page_pulse) begin
         page_reg   <= sel_page;
         frozen_reg <= 1'b0;
         value_reg  <= sel_word;
         enable_reg <= sel_mask;
         timer_reg  <= '0;
      end else begin
         timer_reg <= refresh_tick ? '0 : timer_reg + 1'b1;
         if (freeze_pulse) begin
            frozen_reg <= ~frozen_reg;
         end else if (refresh_tick && !frozen_reg) begin
            value_reg  <= sel_word;
            enable_reg <= sel_mask;
         end
      end
   end

   assign bus.value  = value_reg;
   assign bus.enable = enable_reg;
   assign bus.page   = page_reg;
   assign bus.frozen = frozen_reg;
endmodule

// File: tb/tb_led_value_capture.sv
// Randomised and directed checks of led_value_capture against a cycle-level
// behavioural model built from run lengths and digit counts.
module tb_led_value_capture;
   localparam int D = 4;
   localparam int R = 10;

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;

   led_value_capture_if bus ();

   led_value_capture #(.DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Model state: raw input delayed two edges, accepted level, run of differing samples.
   bit          m_s1 [2];
   bit          m_s2 [2];
   bit          m_lvl [2];
   int          m_run [2];
   int          m_timer;
   int          m_page;
   bit          m_frozen;
   logic [31:0] m_value;
   logic [7:0]  m_enable;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Show as many digits as the highest nonzero nibble needs, never fewer than one.
   function automatic logic [7:0] digits_mask(input logic [31:0] w);
      int nd = 1;
      for (int i = 1; i < 8; i++)
         if (((w >> (4 * i)) & 32'hF) != 0) nd = i + 1;
      return 8'((1 << nd) - 1);
   endfunction

   function automatic logic [31:0] src_word(input int p);
      return bus.src_data[32*p +: 32];
   endfunction

   task automatic set_src(input int p, input logic [31:0] w);
      bus.src_data[32*p +: 32] = w;
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
      end
      m_timer = 0; m_page = 0; m_frozen = 0; m_value = '0; m_enable = 8'h01;
   endtask

   task automatic model_load(input int p);
      m_value  = src_word(p);
      m_enable = digits_mask(m_value);
   endtask

   task automatic model_edge();
      bit raw [2];
      bit pulse [2];
      bit tick;
      raw[0] = bus.btn_page;
      raw[1] = bus.btn_freeze;
      for (int b = 0; b < 2; b++) begin
         pulse[b] = 0;
         if (m_s2[b] != m_lvl[b]) begin
            m_run[b]++;
            if (m_run[b] == D) begin
               m_lvl[b] = m_s2[b];
               m_run[b] = 0;
               pulse[b] = m_lvl[b];
            end
         end else begin
            m_run[b] = 0;
         end
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
      end
      tick = (m_timer == R - 1);
      if (pulse[0]) begin
         m_page   = (m_page + 1) % 4;
         m_frozen = 0;
         m_timer  = 0;
         model_load(m_page);
      end else begin
         m_timer = (m_timer + 1) % R;
         if (pulse[1]) m_frozen = !m_frozen;
         else if (tick && !m_frozen) model_load(m_page);
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      if (reset_n) model_edge();
      @(negedge clk);
      check_value("value", bus.value, m_value);
      check_value("enable", 32'(bus.enable), 32'(m_enable));
      check_value("page", 32'(bus.page), 32'(m_page));
      check_value("frozen", 32'(bus.frozen), 32'(m_frozen));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick_cycle();
   endtask

   task automatic press(input bit pg, input bit fr, input int hold);
      bus.btn_page = pg;
      bus.btn_freeze = fr;
      run(hold);
      bus.btn_page = 0;
      bus.btn_freeze = 0;
      run(8);
      $display("press page=%0b freeze=%0b -> page=%0d frozen=%0b value=%h", pg, fr,
               bus.page, bus.frozen, bus.value);
   endtask

   task automatic async_reset_checks(input string tag);
      check_value({tag, "_value"}, bus.value, 32'h0);
      check_value({tag, "_enable"}, 32'(bus.enable), 32'h01);
      check_value({tag, "_page"}, 32'(bus.page), 32'h0);
      check_value({tag, "_frozen"}, 32'(bus.frozen), 32'h0);
   endtask

   initial begin
      int seq [7] = '{2, 3, 0, 1, 2, 3, 0};
      reset_n = 1'b0;
      bus.btn_page = 0;
      bus.btn_freeze = 0;
      bus.src_data = '0;
      set_src(0, 32'h0000_1A3F);
      set_src(1, 32'h8000_0000);
      set_src(2, 32'h0010_0000);
      set_src(3, 32'h0000_0000);
      model_reset();
      run(3);
      async_reset_checks("rst");

      // First periodic load lands on the tenth edge after release.
      reset_n = 1'b1;
      run(9);
      check_value("pre_tick_value", bus.value, 32'h0);
      run(1);
      check_value("tick_value", bus.value, 32'h0000_1A3F);
      check_value("tick_enable", 32'(bus.enable), 32'h0F);

      // Short glitch is rejected.
      bus.btn_page = 1;
      run(3);
      bus.btn_page = 0;
      run(10);
      check_value("glitch_page", 32'(bus.page), 32'h0);

      // Held press qualifies D+2 edges after it starts, once.
      bus.btn_page = 1;
      run(D + 1);
      check_value("early_page", 32'(bus.page), 32'h0);
      run(1);
      check_value("held_page", 32'(bus.page), 32'h1);
      check_value("held_value", bus.value, 32'h8000_0000);
      check_value("held_enable", 32'(bus.enable), 32'hFF);
      run(2);
      bus.btn_page = 0;
      run(10);
      check_value("release_page", 32'(bus.page), 32'h1);

      for (int i = 0; i < 7; i++) begin
         press(1, 0, 8);
         check_value("wrap_page", 32'(bus.page), 32'(seq[i]));
      end

      // Freeze holds the value while the source moves.
      set_src(0, 32'h0000_0005);
      run(12);
      check_value("frz_pre", bus.value, 32'h5);
      press(0, 1, 8);
      check_value("frz_on", 32'(bus.frozen), 32'h1);
      set_src(0, 32'h0000_0777);
      run(30);
      check_value("frz_hold", bus.value, 32'h5);
      press(0, 1, 8);
      check_value("frz_off", 32'(bus.frozen), 32'h0);
      run(12);
      check_value("unfrz_value", bus.value, 32'h0000_0777);
      check_value("unfrz_enable", 32'(bus.enable), 32'h07);

      // Both buttons together while frozen: page wins and clears freeze.
      press(0, 1, 8);
      set_src(1, 32'h0010_0000);
      press(1, 1, 8);
      check_value("both_page", 32'(bus.page), 32'h1);
      check_value("both_frozen", 32'(bus.frozen), 32'h0);
      check_value("both_value", bus.value, 32'h0010_0000);
      check_value("both_enable", 32'(bus.enable), 32'h3F);

      // Land a freeze pulse on the refresh tick: the tick must not load.
      for (int i = 0; i < R + 2 && m_timer != R - 2 - D; i++) tick_cycle();
      set_src(1, 32'hDEAD_BEEF);
      bus.btn_freeze = 1;
      run(D + 2);
      check_value("align_frozen", 32'(bus.frozen), 32'h1);
      check_value("align_value", bus.value, 32'h0010_0000);
      bus.btn_freeze = 0;
      run(8);
      press(0, 1, 8);

      // Reset in the middle of a debounce with page=2, frozen=1.
      press(1, 0, 8);
      press(0, 1, 8);
      check_value("pre_rst_page", 32'(bus.page), 32'h2);
      check_value("pre_rst_frozen", 32'(bus.frozen), 32'h1);
      bus.btn_page = 1;
      run(4);
      reset_n = 1'b0;
      #1;
      model_reset();
      async_reset_checks("mid_rst");
      run(3);
      reset_n = 1'b1;
      run(D + 1);
      check_value("requal_early", 32'(bus.page), 32'h0);
      run(1);
      check_value("requal_page", 32'(bus.page), 32'h1);
      bus.btn_page = 0;
      run(10);

      // Random buttons, sources and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) bus.btn_page = ~bus.btn_page;
         if ($urandom_range(0, 5) == 0) bus.btn_freeze = ~bus.btn_freeze;
         if ($urandom_range(0, 7) == 0)
            set_src(int'($urandom_range(0, 3)), $urandom >> $urandom_range(0, 32));
         if ($urandom_range(0, 499) == 0) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            async_reset_checks("rand_rst");
            tick_cycle();
            reset_n = 1'b1;
         end
         tick_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/led_value_capture.md
Name: led_value_capture

Overview:
- Upstream feeder for the 8-digit seven-segment driver. It produces the 32-bit hex value and the 8-bit digit-enable mask that the driver scans out.
- Selects one of four 32-bit debug sources from the NES core, such as PC, bus address and data, or a frame counter.
- Rate-limits display updates so they stay readable, and blanks leading zeros.
- Two push-buttons are debounced on-chip: one steps to the next page, the other freezes and unfreezes the shown value.

Parameters:
DEBOUNCE_CYCLES, 200000, consecutive stable samples required before a button level change is accepted (~10 ms at the system clock)
REFRESH_CYCLES, 2000000, period in cycles between display value reloads (~100 ms)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
src_data  input  128  four debug sources; page p occupies bits [32p+31:32p]
btn_page  input  1  raw, asynchronous, active-high "next page" button
btn_freeze  input  1  raw, asynchronous, active-high freeze-toggle button
value  output  32  value to display, registered
enable  output  8  digit enable mask, bit i = digit i (nibble i), registered
page  output  2  currently selected source
frozen  output  1  1 = value held, periodic reloads suppressed

Behaviour:
- Reset (reset_n=0, asynchronous assert, synchronous-to-clk deassert is handled externally):
  - value=0, enable=8'h01, page=0, frozen=0, refresh timer=0.
  - Both synchronizers, both debounced levels and both debounce counters = 0.
- Button path, identical for each button:
  - Two-flop synchronizer.
  - Debounce counter, width clog2(DEBOUNCE_CYCLES+1). It clears whenever the synchronized sample equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the sample and the counter clears.
  - A 0->1 transition of the debounced level produces a one-cycle pulse (page_pulse / freeze_pulse).
  - A 1->0 transition produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1, then wraps to 0. It runs free, including while frozen.
  - refresh_tick = (timer == REFRESH_CYCLES-1).
- Load event, priority order:
  1. page_pulse: page <= page+1, wrapping 3->0; frozen <= 0; load from the NEW page's source in the same edge; timer <= 0.
  2. Otherwise freeze_pulse: frozen <= ~frozen. No load in that cycle. A refresh_tick in the same cycle is ignored.
  3. Otherwise refresh_tick with frozen=0: load from the current page.
  4. Otherwise: value, enable and page hold.
- Simultaneous page_pulse and freeze_pulse: the page action wins, frozen ends at 0, and the freeze press is discarded.
- Load action, all in one clock edge:
  - value <= selected src word, where the selection uses the post-increment page for a page load.
  - enable <= blanking mask of that same word.
  - Latency: the value sampled at edge N is visible after edge N. src_data is sampled only at load edges.
- Blanking mask:
  - enable[i] = 1 if any nibble j >= i of the loaded word is nonzero.
  - enable[0] is forced to 1, so a zero value shows a single "0".
  - Examples: 32'h0000_0000 -> 8'h01; 32'h0000_1A3F -> 8'h0F; 32'h8000_0000 -> 8'hFF; 32'h0010_0000 -> 8'h3F.
- frozen and page are registered outputs and change on the pulse edge.
- Reset asserted mid-debounce or mid-refresh: all state returns to its reset values immediately. A button held across reset release must be re-qualified, and it produces a pulse after DEBOUNCE_CYCLES+2 cycles.

Test Plan:
- Use bench parameters DEBOUNCE_CYCLES=4 and REFRESH_CYCLES=10 throughout.
- Reset: hold reset_n=0 with buttons at 0 -> value=0, enable=8'h01, page=0, frozen=0. Release; src page0=32'h0000_1A3F -> at timer wrap (10th cycle) value=32'h0000_1A3F, enable=8'h0F.
- Debounce: pulse btn_page high for 3 cycles -> page stays 0. Hold it high for 8 cycles -> exactly one increment (page=1) about 6 cycles after the press, and none on release. value=src page1=32'h8000_0000, enable=8'hFF on the same edge.
- Page wrap: four qualified page presses from page=0 -> page sequence 1,2,3,0. Each press loads immediately and resets the timer, so the next periodic load comes 10 cycles later.
- Freeze: with page0=32'h0000_0005, press freeze -> frozen=1. Change page0 to 32'h0000_0777 and wait 30 cycles -> value stays 32'h0000_0005. Press freeze again -> frozen=0, and the next tick loads 32'h0000_0777 with enable=8'h07.
- Simultaneous events: qualify both buttons on the same cycle while frozen=1 -> page increments, frozen=0, and the new page's value loads. Separately, align freeze_pulse with refresh_tick -> no load that cycle.
- Reset mid-operation: assert reset_n=0 at debounce count 2 with page=2 and frozen=1 -> all outputs return to reset values at once, and no pulse follows the release until re-qualification.
